// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: parity selection and the TX frame FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Power-of-two transmit FIFO with combinational head read; push ignores same-cycle pop when full.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO feeds a start/data/parity/stop framer with registered line output.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int      FREQUENCY  = 10000000,
  parameter int      BAUD_RATE  = 9600,
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_dv,
  input  logic [DATA_BITS-1:0]          tx_byte,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_active,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("uart_tx_param: FREQUENCY/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, cnt_nxt;
  logic [BIT_W-1:0]     bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_nxt;
  logic                 serial_nxt, active_nxt, done_nxt;
  logic                 bit_end, load, pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_dv),
    .pop   (pop),
    .din   (tx_byte),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_ready = !fifo_full;
  assign bit_end  = (clk_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= TX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= cnt_nxt;
      bit_idx   <= idx_nxt;
      shreg     <= shreg_nxt;
      par_bit   <= par_nxt;
      tx_serial <= serial_nxt;
      tx_active <= active_nxt;
      tx_done   <= done_nxt;
    end
  end

  // Next-cycle line value is decided here so tx_serial stays a clean register output.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = bit_end ? '0 : clk_cnt + 1'b1;
    idx_nxt    = bit_idx;
    shreg_nxt  = shreg;
    par_nxt    = par_bit;
    serial_nxt = tx_serial;
    active_nxt = tx_active;
    done_nxt   = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;
    case (state)
      TX_IDLE: begin
        cnt_nxt    = '0;
        serial_nxt = 1'b1;
        active_nxt = 1'b0;
        load       = !fifo_empty;
      end
      TX_START: if (bit_end) begin
        state_nxt  = TX_DATA;
        idx_nxt    = '0;
        serial_nxt = shreg[0];
      end
      TX_DATA: if (bit_end) begin
        shreg_nxt = shreg >> 1;
        if (bit_idx == LAST_BIT) begin
          idx_nxt = '0;
          if (PARITY != PAR_NONE) begin
            state_nxt  = TX_PARITY;
            serial_nxt = par_bit;
          end else begin
            state_nxt  = TX_STOP;
            serial_nxt = 1'b1;
          end
        end else begin
          idx_nxt    = bit_idx + 1'b1;
          serial_nxt = shreg[1];
        end
      end
      TX_PARITY: if (bit_end) begin
        state_nxt  = TX_STOP;
        idx_nxt    = '0;
        serial_nxt = 1'b1;
      end
      TX_STOP: if (bit_end) begin
        if (bit_idx == LAST_STOP) begin
          done_nxt = 1'b1;
          idx_nxt  = '0;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_nxt  = TX_IDLE;
            active_nxt = 1'b0;
          end
        end else begin
          idx_nxt = bit_idx + 1'b1;
        end
      end
      default: begin
        state_nxt  = TX_IDLE;
        cnt_nxt    = '0;
        idx_nxt    = '0;
        serial_nxt = 1'b1;
        active_nxt = 1'b0;
      end
    endcase
    // Pop the head and start a frame; shared by idle launch and back-to-back chaining.
    if (load) begin
      pop        = 1'b1;
      state_nxt  = TX_START;
      cnt_nxt    = '0;
      idx_nxt    = '0;
      shreg_nxt  = fifo_dout;
      par_nxt    = (^fifo_dout) ^ (PARITY == PAR_ODD);
      serial_nxt = 1'b0;
      active_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8N1, 7E2 and 8O1 instances sharing clock and reset.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       dv0, dv1, dv2;
  logic [7:0] byte0, byte2;
  logic [6:0] byte1;
  logic [2:0] rdy, ser, act, done;
  logic [2:0] cnt0, cnt1, cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int dc0 = 0, dc1 = 0, dc2 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done[0]) dc0 <= dc0 + 1;
    if (done[1]) dc1 <= dc1 + 1;
    if (done[2]) dc2 <= dc2 + 1;
  end

  uart_tx_param #(.FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .tx_dv(dv0), .tx_byte(byte0), .tx_ready(rdy[0]),
    .tx_serial(ser[0]), .tx_active(act[0]), .tx_done(done[0]), .fifo_count(cnt0));

  uart_tx_param #(.FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                  .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .tx_dv(dv1), .tx_byte(byte1), .tx_ready(rdy[1]),
    .tx_serial(ser[1]), .tx_active(act[1]), .tx_done(done[1]), .fifo_count(cnt1));

  uart_tx_param #(.FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .tx_dv(dv2), .tx_byte(byte2), .tx_ready(rdy[2]),
    .tx_serial(ser[2]), .tx_active(act[2]), .tx_done(done[2]), .fifo_count(cnt2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line bits in transmit order; par: 0 none, 1 odd, 2 even.
  task automatic mk_frame(input logic [8:0] d, input int nd, input int par, input int stops,
                          output logic [15:0] bits, output int nb);
    logic p;
    bits = '0;
    p    = 1'b0;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      bits[1+i] = d[i];
      p = p ^ d[i];
    end
    nb = 1 + nd;
    if (par != 0) begin
      bits[nb] = (par == 1) ? ~p : p;
      nb++;
    end
    for (int s = 0; s < stops; s++) begin
      bits[nb] = 1'b1;
      nb++;
    end
  endtask

  // Starts at a negedge showing start-bit cycle 'skip'; ends at the negedge after the frame.
  task automatic chk_frame(input int sel, input logic [8:0] d, input int nd, input int par,
                           input int stops, input int skip, input string tag);
    logic [15:0] bits;
    int          nb;
    logic        ok;
    mk_frame(d, nd, par, stops, bits, nb);
    for (int b = 0; b < nb; b++) begin
      ok = 1'b1;
      for (int c = (b == 0) ? skip : 0; c < CPB; c++) begin
        if (ser[sel] !== bits[b] || act[sel] !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", tag, b), 32'(ok), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] d [6];
    int         k;
    int         dc_save;
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    reset = 1'b1;
    dv0 = 1'b0; dv1 = 1'b0; dv2 = 1'b0;
    byte0 = '0; byte1 = '0; byte2 = '0;

    // reset state before any clock edge
    #2;
    chk("rst serial", 32'(ser), 32'h7);
    chk("rst active", 32'(act), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst ready", 32'(rdy), 32'h7);
    chk("rst count", 32'(cnt0), 32'd0);
    @(negedge clk) reset = 1'b0;

    // 8N1 single 0xA5
    @(negedge clk); dv0 = 1'b1; byte0 = 8'hA5;
    @(negedge clk); dv0 = 1'b0;
    chk("8N1 count after write", 32'(cnt0), 32'd1);
    chk("8N1 line still idle", 32'(ser[0]), 32'd1);
    @(negedge clk);
    chk_frame(0, 9'h0A5, 8, 0, 1, 0, "8N1 A5");
    chk("8N1 done pulse", 32'(done[0]), 32'd1);
    chk("8N1 active drop", 32'(act[0]), 32'd0);
    @(negedge clk);
    chk("8N1 done one cycle", 32'(done[0]), 32'd0);
    chk("8N1 done count", 32'(dc0), 32'd1);

    // 7E2 0x35
    @(negedge clk); dv1 = 1'b1; byte1 = 7'h35;
    @(negedge clk); dv1 = 1'b0;
    @(negedge clk);
    chk_frame(1, 9'h035, 7, 2, 2, 0, "7E2 35");
    chk("7E2 done pulse", 32'(done[1]), 32'd1);
    @(negedge clk);
    chk("7E2 done count", 32'(dc1), 32'd1);

    // 8O1 0x00 then 0xFF
    @(negedge clk); dv2 = 1'b1; byte2 = 8'h00;
    @(negedge clk); dv2 = 1'b0;
    @(negedge clk);
    chk_frame(2, 9'h000, 8, 1, 1, 0, "8O1 00");
    chk("8O1 00 done", 32'(done[2]), 32'd1);
    @(negedge clk); dv2 = 1'b1; byte2 = 8'hFF;
    @(negedge clk); dv2 = 1'b0;
    @(negedge clk);
    chk_frame(2, 9'h0FF, 8, 1, 1, 0, "8O1 FF");
    chk("8O1 FF done", 32'(done[2]), 32'd1);
    @(negedge clk);
    chk("8O1 done count", 32'(dc2), 32'd2);

    // streaming writes until full, then hold a write against the full FIFO
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); dv0 = 1'b1; byte0 = d[i];
      if (i == 2) chk("push+pop count", 32'(cnt0), 32'd1);
    end
    @(negedge clk); byte0 = d[5];
    chk("full count", 32'(cnt0), 32'd4);
    chk("full ready low", 32'(rdy[0]), 32'd0);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (cnt0 != 3'd4) break;
      k++;
    end
    chk("full write rejected on pop", 32'(cnt0), 32'd3);
    chk("ready after pop", 32'(rdy[0]), 32'd1);
    chk("chained start bit", 32'(ser[0]), 32'd0);
    @(negedge clk);
    chk("sixth write accepted", 32'(cnt0), 32'd4);
    dv0 = 1'b0;
    chk_frame(0, {1'b0, d[1]}, 8, 0, 1, 1, "b2b 1");
    for (int i = 2; i < 6; i++) chk_frame(0, {1'b0, d[i]}, 8, 0, 1, 0, $sformatf("b2b %0d", i));
    chk("b2b final done", 32'(done[0]), 32'd1);
    chk("b2b final idle", 32'(act[0]), 32'd0);
    @(negedge clk);
    chk("b2b done count", 32'(dc0), 32'd7);

    // reset in the middle of a data bit of frame 2 of 3
    @(negedge clk); dv0 = 1'b1; byte0 = 8'hC1;
    @(negedge clk); byte0 = 8'hC2;
    @(negedge clk); byte0 = 8'hC3;
    @(negedge clk); dv0 = 1'b0;
    repeat (144) @(negedge clk);
    chk("mid frame2 active", 32'(act[0]), 32'd1);
    chk("mid frame2 bit3", 32'(ser[0]), 32'd0);
    chk("mid frame2 queued", 32'(cnt0), 32'd1);
    dc_save = dc0;
    #2 reset = 1'b1;
    #1;
    chk("async rst serial", 32'(ser[0]), 32'd1);
    chk("async rst count", 32'(cnt0), 32'd0);
    chk("async rst active", 32'(act[0]), 32'd0);
    chk("async rst ready", 32'(rdy[0]), 32'd1);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("no done after abort", 32'(dc0), 32'(dc_save));
    chk("line idle after abort", 32'(ser[0]), 32'd1);
    @(negedge clk); dv0 = 1'b1; byte0 = 8'h3C;
    @(negedge clk); dv0 = 1'b0;
    @(negedge clk);
    chk_frame(0, 9'h03C, 8, 0, 1, 0, "post rst 3C");
    chk("post rst done", 32'(done[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
